weight_col_encoder_16: RTL and testbench

- Bit-serial weight sequencer that drives the 16-lane vertical MAC.
- Accepts one 16×8-bit signed weight vector, walks its bit columns MSB→LSB, and emits one beat per column.
- Each beat carries the MAC control fields: per-lane mux select/valid, per-group skip-zero mode, column index and MSB flag.
- Sits between the weight buffer and the MAC array. Its output fields connect straight to the MAC's `act_sel`, `act_val`, `is_skip_zero`, `column_idx` and `is_msb` inputs.

---
 rtl/weight_col_encoder_16.sv | 184 ++++++++++++++++++
 tb/tb_weight_col_encoder_16.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_col_encoder_16.sv
// weight_col_encoder_16
// Bit-serial weight sequencer for the 16-lane vertical MAC. Latches one
// 16 x 8-bit signed weight vector, walks its bit columns MSB to LSB and
// emits one beat of MAC control fields per column.
// Beat fields come only from registered state, never from w_in/w_valid.

module weight_col_encoder_16 #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 16,
    parameter int SEL_WIDTH     = 3,
    parameter int SKIP_ZERO_COL = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]       w_in,
    input  logic                                        w_valid,
    output logic                                        w_ready,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [VEC_LENGTH/2-1:0][SEL_WIDTH-1:0]      act_sel,
    output logic [VEC_LENGTH/2-1:0]                     act_val,
    output logic [VEC_LENGTH/8-1:0]                     is_skip_zero,
    output logic [$clog2(DATA_WIDTH)-1:0]               column_idx,
    output logic                                        is_msb,
    output logic                                        out_last
);

    localparam int GROUP_SIZE      = 8;
    localparam int LANES_PER_GROUP = 4;
    localparam int NUM_GROUPS      = VEC_LENGTH / GROUP_SIZE;
    localparam int NUM_LANES       = NUM_GROUPS * LANES_PER_GROUP;
    localparam int COL_W           = $clog2(DATA_WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]                              state;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   w_reg;
    logic [COL_W-1:0]                        col;

    logic [DATA_WIDTH-1:0]                   in_col_nz;
    logic [DATA_WIDTH-1:0]                   reg_col_nz;
    logic [COL_W-1:0]                        first_col;
    logic [COL_W-1:0]                        next_col;
    logic [VEC_LENGTH-1:0]                   col_bits;

    logic [NUM_LANES-1:0][SEL_WIDTH-1:0]     enc_sel;
    logic [NUM_LANES-1:0]                    enc_val;
    logic [NUM_GROUPS-1:0]                   enc_skz;

    logic                                    beat_fire;
    logic                                    last_fire;
    logic                                    accept;

    // Handshake terms shared by the FSM and the ready output
    always_comb begin
        out_valid = (state == ST_RUN);
        out_last  = out_valid && (col == '0);
        beat_fire = out_valid && out_ready;
        last_fire = beat_fire && out_last;
        w_ready   = (state == ST_IDLE) || last_fire;
        accept    = w_valid && w_ready;
    end

    // Per-column "any bit set" flags for the incoming and the latched vector
    always_comb begin
        in_col_nz  = '0;
        reg_col_nz = '0;
        for (int unsigned c = 0; c < DATA_WIDTH; c++) begin
            for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
                in_col_nz[c]  = in_col_nz[c]  | w_in[i][c];
                reg_col_nz[c] = reg_col_nz[c] | w_reg[i][c];
            end
        end
    end

    // First emitted column of an incoming vector: highest non-empty column, else 0
    always_comb begin
        first_col = '0;
        if (SKIP_ZERO_COL == 0) begin
            first_col = COL_W'(DATA_WIDTH - 1);
        end else begin
            for (int unsigned c = 0; c < DATA_WIDTH; c++) begin
                if (in_col_nz[c]) begin
                    first_col = COL_W'(c);
                end
            end
        end
    end

    // Next column: highest non-empty column strictly below the current one, else 0
    always_comb begin
        next_col = '0;
        if (SKIP_ZERO_COL == 0) begin
            next_col = col - COL_W'(1);
        end else begin
            for (int unsigned c = 0; c < DATA_WIDTH; c++) begin
                if (reg_col_nz[c] && (COL_W'(c) < col)) begin
                    next_col = COL_W'(c);
                end
            end
        end
    end

    // Sequencer: accept has priority so a new vector on the last-beat cycle
    // keeps the encoder in RUN without a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            w_reg <= '0;
            col   <= '0;
        end else if (accept) begin
            state <= ST_RUN;
            w_reg <= w_in;
            col   <= first_col;
        end else if (last_fire) begin
            state <= ST_IDLE;
        end else if (beat_fire) begin
            col   <= next_col;
        end
    end

    // Extract the current bit column of the latched vector
    always_comb begin
        col_bits = '0;
        for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
            col_bits[i] = w_reg[i][col];
        end
    end

    // Per-group encoding: encode the minority bit value (ties encode ones),
    // then pack encoded positions greedily onto the 4 mux lanes, each lane
    // taking the lowest position it can still reach (lane..lane+4)
    always_comb begin
        logic [GROUP_SIZE-1:0] grp_bits;
        logic [GROUP_SIZE-1:0] enc_pos;
        logic [3:0]            next_lane;
        logic [3:0]            low_lane;
        logic [3:0]            lane;

        enc_sel   = '0;
        enc_val   = '0;
        enc_skz   = '0;
        grp_bits  = '0;
        enc_pos   = '0;
        next_lane = '0;
        low_lane  = '0;
        lane      = '0;

        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            grp_bits = col_bits[g*GROUP_SIZE +: GROUP_SIZE];
            if ($countones(grp_bits) <= LANES_PER_GROUP) begin
                enc_skz[g] = 1'b1;
                enc_pos    = grp_bits;
            end else begin
                enc_skz[g] = 1'b0;
                enc_pos    = ~grp_bits;
            end

            next_lane = '0;
            for (int unsigned p = 0; p < GROUP_SIZE; p++) begin
                if (enc_pos[p]) begin
                    low_lane = (p >= LANES_PER_GROUP) ? 4'(p - LANES_PER_GROUP) : 4'd0;
                    lane     = (next_lane > low_lane) ? next_lane : low_lane;
                    if (lane < 4'(LANES_PER_GROUP)) begin
                        enc_val[g*LANES_PER_GROUP + int'(lane)] = 1'b1;
                        enc_sel[g*LANES_PER_GROUP + int'(lane)] = SEL_WIDTH'(4'(p) - lane);
                    end
                    next_lane = lane + 4'd1;
                end
            end
        end
    end

    // Beat outputs, forced to zero whenever no beat is being presented
    always_comb begin
        act_sel      = out_valid ? enc_sel : '0;
        act_val      = out_valid ? enc_val : '0;
        is_skip_zero = out_valid ? enc_skz : '0;
        column_idx   = out_valid ? col : '0;
        is_msb       = out_valid && (col == COL_W'(DATA_WIDTH - 1));
    end

endmodule

// File: tb/tb_weight_col_encoder_16.sv
// Self-checking bench for weight_col_encoder_16: table of single-column
// vectors, hand sequences for multi-beat corners, and randomized traffic
// scored against a queue-based reference model.

module tb_weight_col_encoder_16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [15:0][7:0]      w_in;
    logic                  w_valid;
    logic                  w_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0][2:0]       act_sel;
    logic [7:0]            act_val;
    logic [1:0]            is_skip_zero;
    logic [2:0]            column_idx;
    logic                  is_msb;
    logic                  out_last;

    weight_col_encoder_16 #(
        .DATA_WIDTH   (8),
        .VEC_LENGTH   (16),
        .SEL_WIDTH    (3),
        .SKIP_ZERO_COL(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .w_in        (w_in),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .act_sel     (act_sel),
        .act_val     (act_val),
        .is_skip_zero(is_skip_zero),
        .column_idx  (column_idx),
        .is_msb      (is_msb),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // beat = {sel[23:0], val[7:0], skz[1:0], col[2:0], msb, last}
    logic [38:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic        prev_acc = 1'b0;
    logic        stalled = 1'b0;
    logic [38:0] held_beat = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [38:0] cur_beat();
        return {act_sel, act_val, is_skip_zero, column_idx, is_msb, out_last};
    endfunction

    // Reference model: emit every non-empty column (plus column 0) high to low
    task automatic model_push(input logic [15:0][7:0] w);
        for (int c = 7; c >= 0; c--) begin
            logic [15:0]     bits;
            logic [7:0][2:0] sel;
            logic [7:0]      val;
            logic [1:0]      skz;
            for (int i = 0; i < 16; i++) bits[i] = w[i][c];
            if (bits == 16'h0 && c != 0) continue;
            sel = '0;
            val = '0;
            skz = '0;
            for (int g = 0; g < 2; g++) begin
                logic [7:0] b;
                logic [7:0] s;
                int         k;
                int         prev;
                b = bits[g*8 +: 8];
                k = $countones(b);
                if (k <= 4) begin skz[g] = 1'b1; s = b;  end
                else        begin skz[g] = 1'b0; s = ~b; end
                prev = -1;
                for (int p = 0; p < 8; p++) begin
                    if (s[p]) begin
                        int lane;
                        lane = (prev + 1 > p - 4) ? prev + 1 : p - 4;
                        sel[g*4 + lane] = 3'(p - lane);
                        val[g*4 + lane] = 1'b1;
                        prev = lane;
                    end
                end
            end
            exp_q.push_back({sel, val, skz, 3'(c), (c == 7), (c == 0)});
        end
    endtask

    // Scoreboard / protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_acc = 1'b0;
            stalled  = 1'b0;
        end else if (!mon_en) begin
            prev_acc = 1'b0;
            stalled  = 1'b0;
        end else begin
            if (prev_acc) chk("first_beat_latency", out_valid, 1);
            if (stalled)  chk("hold_stable", {out_valid, cur_beat()}, {1'b1, held_beat});
            if (!out_valid) chk("idle_fields_zero", cur_beat(), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", cur_beat(), 0);
                    if (cur_beat() == 0) chk("unexpected_beat_valid", out_valid, 0);
                end else begin
                    chk("beat", cur_beat(), exp_q.pop_front());
                end
            end
            if (w_valid && w_ready) model_push(w_in);
            prev_acc  = w_valid && w_ready;
            stalled   = out_valid && !out_ready;
            held_beat = cur_beat();
        end
    end

    // Called at posedge+1; waits (bounded) for the next accept edge
    task automatic wait_accept(output logic ok, output logic was_last);
        ok = 1'b0;
        was_last = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            #2;
            if (w_valid && w_ready) begin
                ok = 1'b1;
                was_last = out_valid && out_last;
            end
            @(posedge clk); #1;
        end
        chk("accept_within_bound", ok, 1);
    endtask

    typedef struct {
        logic [15:0]     col0;
        logic [7:0][2:0] sel;
        logic [7:0]      val;
        logic [1:0]      skz;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic ok, was_last;
        logic [15:0][7:0] w;
        logic [7:0] m;
        int accepted;

        tbl[0] = '{16'h00E0, {3'd0,3'd0,3'd0,3'd0,3'd4,3'd4,3'd4,3'd0}, 8'b0000_1110, 2'b11};
        tbl[1] = '{16'h0081, {3'd0,3'd0,3'd0,3'd0,3'd4,3'd0,3'd0,3'd0}, 8'b0000_1001, 2'b11};
        tbl[2] = '{16'h00AA, {3'd0,3'd0,3'd0,3'd0,3'd4,3'd3,3'd2,3'd1}, 8'b0000_1111, 2'b11};
        tbl[3] = '{16'h001F, {3'd0,3'd0,3'd0,3'd0,3'd4,3'd4,3'd4,3'd0}, 8'b0000_1110, 2'b10};
        tbl[4] = '{16'hFFFF, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 8'b0000_0000, 2'b00};
        tbl[5] = '{16'h1400, {3'd0,3'd0,3'd3,3'd2,3'd0,3'd0,3'd0,3'd0}, 8'b0011_0000, 2'b11};
        tbl[6] = '{16'h3F00, {3'd4,3'd4,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 8'b1100_0000, 2'b01};

        reset = 1'b1; w_valid = 1'b0; out_ready = 1'b0; w_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_fields", cur_beat(), 0);
        reset = 1'b0;
        #1;
        chk("reset_w_ready", w_ready, 1);

        // Single-beat vectors: only column 0 carries bits
        for (int t = 0; t < 7; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 16; i++) w_in[i] = {7'd0, tbl[t].col0[i]};
            w_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            w_valid = 1'b0;
            chk($sformatf("table%0d_beat", t), {out_valid, cur_beat()},
                {1'b1, tbl[t].sel, tbl[t].val, tbl[t].skz, 3'd0, 1'b0, 1'b1});
            @(posedge clk); #1;
            chk($sformatf("table%0d_done", t), out_valid, 0);
        end

        // w[0]=0x80: column 7 then column 0, columns 6..1 skipped
        w_in = '0; w_in[0] = 8'h80; w_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        w_valid = 1'b0;
        chk("msb_beat1", {out_valid, cur_beat()},
            {1'b1, 24'd0, 8'b0000_0001, 2'b11, 3'd7, 1'b1, 1'b0});
        @(posedge clk); #1;
        chk("msb_beat2", {out_valid, cur_beat()},
            {1'b1, 24'd0, 8'b0000_0000, 2'b11, 3'd0, 1'b0, 1'b1});
        @(posedge clk); #1;
        chk("msb_done", out_valid, 0);

        mon_en = 1'b1;
        @(posedge clk); #1;

        // Backpressure: stall the column-6 beat for 3 cycles
        for (int i = 0; i < 16; i++) w_in[i] = 8'($urandom);
        w_in[0] = 8'hFF; w_valid = 1'b1; out_ready = 1'b1;
        wait_accept(ok, was_last);
        w_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #2;
            chk("stall_column", {out_valid, column_idx}, {1'b1, 3'd6});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int n = 0; n < 7; n++) begin
            #2;
            chk("release_column", {out_valid, column_idx}, {1'b1, 3'(6 - n)});
            @(posedge clk); #1;
        end
        chk("release_done", out_valid, 0);

        // Back-to-back: second vector accepted on the last-beat cycle
        w_in = '0; w_in[0] = 8'h81; w_valid = 1'b1; out_ready = 1'b1;
        wait_accept(ok, was_last);
        w_in = '0; w_in[3] = 8'h24;
        wait_accept(ok, was_last);
        chk("b2b_ready_on_last", was_last, 1);
        w_valid = 1'b0;
        chk("b2b_no_gap", {out_valid, column_idx}, {1'b1, 3'd5});
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of an 8-beat vector
        for (int i = 0; i < 16; i++) w_in[i] = 8'($urandom);
        w_in[0] = 8'hFF; w_valid = 1'b1; out_ready = 1'b1;
        wait_accept(ok, was_last);
        w_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrun_reset_idle", {out_valid, w_ready}, {1'b0, 1'b1});
        for (int n = 0; n < 10; n++) begin
            #2;
            chk("midrun_no_leftover", out_valid, 0);
            @(posedge clk); #1;
        end

        // Randomized traffic with random backpressure
        accepted = 0;
        w_valid = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!w_valid && $urandom_range(0, 2) != 0) begin
                m = 8'($urandom);
                for (int i = 0; i < 16; i++) w[i] = 8'($urandom) & m;
                if ($urandom_range(0, 7) == 0) w = '0;
                w_in = w;
                w_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            ok = w_valid && w_ready;
            @(posedge clk); #1;
            if (ok) begin
                w_valid = 1'b0;
                accepted++;
            end
        end
        w_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 20 && out_valid; n++) begin
            @(posedge clk); #1;
        end
        #5;
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_idle", out_valid, 0);
        chk("random_vectors_accepted", (accepted > 100), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
